// File: rtl/lock_pkg.sv
// ---------------------------------------------------------------------------
// lock_pkg
//  Shared definitions for the digital lock sequencer.
//  - state_t       : sequencer state encoding
//  - CMP_*         : compare_type values driven to the code checker
//  - KEY_*_DEF     : default key codes for the control keys
//  - is_wait()     : true for the states that wait on a checker verdict
//  - cnt_width()   : counter width able to hold a given count value
// ---------------------------------------------------------------------------
package lock_pkg;

    typedef enum logic [3:0] {
        ST_LOCKED   = 4'd0,
        ST_WAIT_UC  = 4'd1,
        ST_UNLOCKED = 4'd2,
        ST_NEW1     = 4'd3,
        ST_WAIT_ST  = 4'd4,
        ST_NEW2     = 4'd5,
        ST_WAIT_MT  = 4'd6,
        ST_COMMIT   = 4'd7,
        ST_PC_ENTRY = 4'd8,
        ST_WAIT_PC  = 4'd9
    } state_t;

    localparam logic [1:0] CMP_PC    = 2'b00;
    localparam logic [1:0] CMP_UC    = 2'b01;
    localparam logic [1:0] CMP_MATCH = 2'b10;
    localparam logic [1:0] CMP_STORE = 2'b11;

    localparam logic [3:0] KEY_SUBMIT_DEF = 4'd8;
    localparam logic [3:0] KEY_CHANGE_DEF = 4'd9;

    function automatic logic is_wait(input state_t s);
        return (s == ST_WAIT_UC) || (s == ST_WAIT_PC) ||
               (s == ST_WAIT_ST) || (s == ST_WAIT_MT);
    endfunction

    // Width needed to represent values 0..n (minimum 1 bit).
    function automatic int cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// ---------------------------------------------------------------------------
// lock_timer
//  Loadable down-counter that stops at zero.
//  Ports:
//   hwclk      in  clock
//   rst        in  asynchronous active-high reset (count -> 0)
//   load       in  load load_value (takes priority over enable)
//   enable     in  decrement while count is non-zero
//   load_value in  WIDTH-bit reload value
//   expired    out count is zero
// ---------------------------------------------------------------------------
module lock_timer #(
    parameter int WIDTH = 8
) (
    input  logic             hwclk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && (count_reg != '0)) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/lock_sequencer.sv
// ---------------------------------------------------------------------------
// lock_sequencer
//  Top-level sequencing FSM for the digital lock. Reacts to SUBMIT/CHANGE key
//  strobes, steers the code checker and decides lock state: user-code unlock,
//  code change with confirmation, and programmer-code recovery after
//  MAX_TRIES wrong submits.
//  Ports:
//   hwclk          in   system clock
//   rst            in   asynchronous active-high reset
//   key_valid      in   one-cycle key strobe
//   key_code [3:0] in   decoded key value
//   chk_correct    in   checker verdict
//   chk_dataready  in   checker verdict valid
//   read_input     out  checker may shift in digits
//   compare_type   out  00 PC, 01 UC, 10 MATCH UC, 11 STORE UC
//   store          out  one-cycle commit pulse for the new user code
//   unlocked       out  lock open
//   alarm          out  high while waiting for the programmer code
//   tries [1:0]    out  saturating wrong-submit count
//  All outputs are registered: they are decoded from the next state and
//  captured alongside the state register.
// ---------------------------------------------------------------------------
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int unsigned MAX_TRIES     = 3,
    parameter int unsigned UNLOCK_CYCLES = 12_000_000,
    parameter int unsigned RESP_TIMEOUT  = 16,
    parameter logic [3:0]  KEY_SUBMIT    = KEY_SUBMIT_DEF,
    parameter logic [3:0]  KEY_CHANGE    = KEY_CHANGE_DEF
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       chk_correct,
    input  logic       chk_dataready,
    output logic       read_input,
    output logic [1:0] compare_type,
    output logic       store,
    output logic       unlocked,
    output logic       alarm,
    output logic [1:0] tries
);

    localparam int RELOCK_W = cnt_width(UNLOCK_CYCLES);
    localparam int RESP_W   = cnt_width(RESP_TIMEOUT);

    state_t     state_reg, state_next;
    logic [1:0] tries_reg, tries_next;

    logic       read_input_reg, read_input_next;
    logic [1:0] compare_type_reg, compare_type_next;
    logic       store_reg, store_next;
    logic       unlocked_reg, unlocked_next;
    logic       alarm_reg, alarm_next;

    logic submit, change;
    logic relock_expired, resp_expired;
    logic response, verdict_ok;
    logic [2:0] tries_plus;

    assign submit = key_valid && (key_code == KEY_SUBMIT);
    assign change = key_valid && (key_code == KEY_CHANGE);

    // A verdict is taken on the first dataready cycle; if the timeout runs
    // out first the submit is resolved as wrong. Dataready on the expiry
    // cycle itself still counts as a real answer.
    assign response   = chk_dataready || resp_expired;
    assign verdict_ok = chk_dataready && chk_correct;
    assign tries_plus = {1'b0, tries_reg} + 3'd1;

    // ------------------------------------------------------------------
    // Timers: reload on entry into the owning state, count while in it.
    // ------------------------------------------------------------------
    lock_timer #(.WIDTH(RELOCK_W)) u_relock_timer (
        .hwclk      (hwclk),
        .rst        (rst),
        .load       ((state_next == ST_UNLOCKED) && (state_reg != ST_UNLOCKED)),
        .enable     (state_reg == ST_UNLOCKED),
        .load_value (RELOCK_W'(UNLOCK_CYCLES - 1)),
        .expired    (relock_expired)
    );

    lock_timer #(.WIDTH(RESP_W)) u_resp_timer (
        .hwclk      (hwclk),
        .rst        (rst),
        .load       (is_wait(state_next) && !is_wait(state_reg)),
        .enable     (is_wait(state_reg)),
        .load_value (RESP_W'(RESP_TIMEOUT - 1)),
        .expired    (resp_expired)
    );

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_LOCKED;
            tries_reg        <= 2'd0;
            read_input_reg   <= 1'b1;
            compare_type_reg <= CMP_UC;
            store_reg        <= 1'b0;
            unlocked_reg     <= 1'b0;
            alarm_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            tries_reg        <= tries_next;
            read_input_reg   <= read_input_next;
            compare_type_reg <= compare_type_next;
            store_reg        <= store_next;
            unlocked_reg     <= unlocked_next;
            alarm_reg        <= alarm_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        tries_next = tries_reg;
        unique case (state_reg)
            ST_LOCKED: begin
                if (submit) state_next = ST_WAIT_UC;
            end
            ST_WAIT_UC: begin
                if (response) begin
                    if (verdict_ok) begin
                        state_next = ST_UNLOCKED;
                        tries_next = 2'd0;
                    end else if (tries_plus >= 3'(MAX_TRIES)) begin
                        // Saturate; reaching the limit hands over to PC entry.
                        state_next = ST_PC_ENTRY;
                        tries_next = 2'(MAX_TRIES);
                    end else begin
                        state_next = ST_LOCKED;
                        tries_next = tries_plus[1:0];
                    end
                end
            end
            ST_PC_ENTRY: begin
                if (submit) state_next = ST_WAIT_PC;
            end
            ST_WAIT_PC: begin
                if (response) begin
                    if (verdict_ok) begin
                        state_next = ST_LOCKED;
                        tries_next = 2'd0;
                    end else begin
                        state_next = ST_PC_ENTRY;
                    end
                end
            end
            ST_UNLOCKED: begin
                // CHANGE beats an expiring relock timer in the same cycle.
                if (change)              state_next = ST_NEW1;
                else if (relock_expired) state_next = ST_LOCKED;
            end
            ST_NEW1: begin
                if (submit) state_next = ST_WAIT_ST;
            end
            ST_WAIT_ST: begin
                if (response) state_next = verdict_ok ? ST_NEW2 : ST_LOCKED;
            end
            ST_NEW2: begin
                if (submit) state_next = ST_WAIT_MT;
            end
            ST_WAIT_MT: begin
                if (response) state_next = verdict_ok ? ST_COMMIT : ST_LOCKED;
            end
            ST_COMMIT: begin
                state_next = ST_LOCKED;
            end
            default: begin
                state_next = ST_LOCKED;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state (registered above)
    // ------------------------------------------------------------------
    always_comb begin
        read_input_next   = 1'b0;
        compare_type_next = CMP_UC;
        store_next        = 1'b0;
        unlocked_next     = 1'b0;
        alarm_next        = 1'b0;
        unique case (state_next)
            ST_LOCKED:   begin compare_type_next = CMP_UC;    read_input_next = 1'b1; end
            ST_WAIT_UC:  begin compare_type_next = CMP_UC;    end
            ST_UNLOCKED: begin compare_type_next = CMP_UC;    unlocked_next = 1'b1; end
            ST_NEW1:     begin compare_type_next = CMP_STORE; read_input_next = 1'b1; end
            ST_WAIT_ST:  begin compare_type_next = CMP_STORE; end
            ST_NEW2:     begin compare_type_next = CMP_MATCH; read_input_next = 1'b1; end
            ST_WAIT_MT:  begin compare_type_next = CMP_MATCH; end
            ST_COMMIT:   begin compare_type_next = CMP_STORE; store_next = 1'b1; end
            ST_PC_ENTRY: begin compare_type_next = CMP_PC;    read_input_next = 1'b1; alarm_next = 1'b1; end
            ST_WAIT_PC:  begin compare_type_next = CMP_PC;    alarm_next = 1'b1; end
            default:     begin compare_type_next = CMP_UC;    read_input_next = 1'b1; end
        endcase
    end

    assign read_input   = read_input_reg;
    assign compare_type = compare_type_reg;
    assign store        = store_reg;
    assign unlocked     = unlocked_reg;
    assign alarm        = alarm_reg;
    assign tries        = tries_reg;

endmodule

// File: tb/tb_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lock_sequencer
//  Self-checking bench: a behavioural model of the lock (mode + waiting
//  flag + elapsed-cycle counters) is compared with the DUT on every falling
//  edge, directed scenarios pin exact expectations, then randomized traffic
//  runs against the model.
// ---------------------------------------------------------------------------
module tb_lock_sequencer;

    localparam int MAX_T   = 3;
    localparam int OPEN_T  = 20;
    localparam int RESP_T  = 16;

    logic       hwclk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       chk_correct = 1'b0;
    logic       chk_dataready = 1'b0;
    logic       read_input;
    logic [1:0] compare_type;
    logic       store;
    logic       unlocked;
    logic       alarm;
    logic [1:0] tries;

    int assert_count = 0;
    int fail_count   = 0;
    int store_cycles = 0;

    always #5 hwclk = ~hwclk;

    lock_sequencer #(
        .MAX_TRIES     (MAX_T),
        .UNLOCK_CYCLES (OPEN_T),
        .RESP_TIMEOUT  (RESP_T),
        .KEY_SUBMIT    (4'd8),
        .KEY_CHANGE    (4'd9)
    ) dut (
        .hwclk         (hwclk),
        .rst           (rst),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .chk_correct   (chk_correct),
        .chk_dataready (chk_dataready),
        .read_input    (read_input),
        .compare_type  (compare_type),
        .store         (store),
        .unlocked      (unlocked),
        .alarm         (alarm),
        .tries         (tries)
    );

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: what the lock is doing, whether a verdict is
    // pending, and how long each timed phase has lasted.
    // ------------------------------------------------------------------
    typedef enum int {M_LOCKED, M_PC, M_OPEN, M_NEW1, M_NEW2, M_COMMIT} mode_t;
    mode_t m_mode;
    bit    m_wait;
    int    m_waited;
    int    m_age;
    int    m_tries;

    task automatic model_resolve(input bit ok);
        m_wait = 0;
        case (m_mode)
            M_LOCKED: begin
                if (ok) begin
                    m_mode = M_OPEN; m_age = 0; m_tries = 0;
                end else begin
                    m_tries = (m_tries + 1 > MAX_T) ? MAX_T : m_tries + 1;
                    m_mode  = (m_tries == MAX_T) ? M_PC : M_LOCKED;
                end
            end
            M_PC:   if (ok) begin m_mode = M_LOCKED; m_tries = 0; end
            M_NEW1: m_mode = ok ? M_NEW2 : M_LOCKED;
            M_NEW2: m_mode = ok ? M_COMMIT : M_LOCKED;
            default: m_mode = M_LOCKED;
        endcase
    endtask

    task automatic model_step();
        bit sub, chg;
        sub = key_valid && key_code == 4'd8;
        chg = key_valid && key_code == 4'd9;
        if (m_wait) begin
            if (chk_dataready) begin
                model_resolve(chk_correct);
            end else begin
                m_waited++;
                if (m_waited == RESP_T) model_resolve(1'b0);
            end
        end else begin
            case (m_mode)
                M_LOCKED, M_PC, M_NEW1, M_NEW2:
                    if (sub) begin m_wait = 1; m_waited = 0; end
                M_OPEN: begin
                    if (chg) begin
                        m_mode = M_NEW1;
                    end else begin
                        m_age++;
                        if (m_age == OPEN_T) m_mode = M_LOCKED;
                    end
                end
                default: m_mode = M_LOCKED;  // COMMIT lasts one cycle
            endcase
        end
    endtask

    always @(posedge hwclk or posedge rst) begin
        if (rst) begin
            m_mode = M_LOCKED; m_wait = 0; m_waited = 0; m_age = 0; m_tries = 0;
        end else begin
            model_step();
        end
    end

    function automatic logic [1:0] model_cmp();
        case (m_mode)
            M_PC:     return 2'b00;
            M_NEW1:   return 2'b11;
            M_NEW2:   return 2'b10;
            M_COMMIT: return 2'b11;
            default:  return 2'b01;
        endcase
    endfunction

    // Continuous comparison against the model.
    always @(negedge hwclk) begin
        if (!rst) begin
            chk("model.read_input", read_input,
                (!m_wait && m_mode != M_OPEN && m_mode != M_COMMIT) ? 1 : 0);
            chk("model.compare_type", compare_type, model_cmp());
            chk("model.store", store, (m_mode == M_COMMIT) ? 1 : 0);
            chk("model.unlocked", unlocked, (m_mode == M_OPEN) ? 1 : 0);
            chk("model.alarm", alarm, (m_mode == M_PC) ? 1 : 0);
            chk("model.tries", tries, m_tries);
            if (store) store_cycles++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1; key_code = code;
        tick();
        key_valid = 1'b0; key_code = 4'd0;
    endtask

    task automatic respond(input logic ok);
        chk_dataready = 1'b1; chk_correct = ok;
        tick();
        chk_dataready = 1'b0; chk_correct = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".read_input"}, read_input, 1);
        chk({tag, ".compare_type"}, compare_type, 1);
        chk({tag, ".store"}, store, 0);
        chk({tag, ".unlocked"}, unlocked, 0);
        chk({tag, ".alarm"}, alarm, 0);
        chk({tag, ".tries"}, tries, 0);
    endtask

    int snap;

    initial begin
        // 1: reset, unlock, auto-relock
        ticks(3);
        rst = 1'b0;
        tick();
        check_reset_values("reset");
        press(4'd8);
        chk("t1.wait_read_input", read_input, 0);
        respond(1'b1);
        chk("t1.unlocked", unlocked, 1);
        chk("t1.tries", tries, 0);
        ticks(OPEN_T - 1);
        chk("t1.still_open", unlocked, 1);
        tick();
        chk("t1.relocked", unlocked, 0);
        $display("t1 unlock/relock done");

        // 2: three wrong submits -> PC entry
        for (int i = 1; i <= 3; i++) begin
            press(4'd8);
            respond(1'b0);
            chk("t2.tries", tries, i);
        end
        chk("t2.alarm", alarm, 1);
        chk("t2.compare_type", compare_type, 0);
        $display("t2 lockout done, tries=%0d", tries);

        // 3: programmer code recovers
        press(4'd8);
        respond(1'b1);
        chk("t3.alarm", alarm, 0);
        chk("t3.tries", tries, 0);
        chk("t3.compare_type", compare_type, 1);
        $display("t3 pc recovery done");

        // 4: code change with confirm
        press(4'd8); respond(1'b1);
        press(4'd9);
        chk("t4.new1_cmp", compare_type, 3);
        chk("t4.new1_unlocked", unlocked, 0);
        press(4'd8); respond(1'b1);
        chk("t4.new2_cmp", compare_type, 2);
        snap = store_cycles;
        press(4'd8); respond(1'b1);
        chk("t4.store_high", store, 1);
        tick();
        chk("t4.store_low", store, 0);
        chk("t4.locked_cmp", compare_type, 1);
        chk("t4.store_cycles", store_cycles - snap, 1);
        $display("t4 code change done");

        // 5: mismatch keeps old code, then response timeout counts as wrong
        snap = store_cycles;
        press(4'd8); respond(1'b1);
        press(4'd9);
        press(4'd8); respond(1'b1);
        press(4'd8); respond(1'b0);
        ticks(2);
        chk("t5.no_store", store_cycles - snap, 0);
        chk("t5.locked_cmp", compare_type, 1);
        press(4'd8);
        ticks(RESP_T - 1);
        chk("t5.pre_timeout_tries", tries, 0);
        chk("t5.pre_timeout_read", read_input, 0);
        tick();
        chk("t5.timeout_tries", tries, 1);
        chk("t5.timeout_read", read_input, 1);
        $display("t5 mismatch/timeout done");

        // 6: asynchronous reset in COMMIT and in WAIT_UC
        press(4'd8); respond(1'b1);
        press(4'd9);
        press(4'd8); respond(1'b1);
        press(4'd8); respond(1'b1);
        chk("t6.in_commit", store, 1);
        #2 rst = 1'b1;
        #1 check_reset_values("t6.commit_rst");
        tick();
        rst = 1'b0;
        press(4'd8);
        chk("t6.in_wait", read_input, 0);
        #2 rst = 1'b1;
        #1 check_reset_values("t6.wait_rst");
        tick();
        rst = 1'b0;
        $display("t6 async reset done");

        // Randomized traffic, checked by the model on every cycle
        for (int blk = 0; blk < 40; blk++) begin
            int dr_pct, key_pct;
            dr_pct  = (blk % 4 == 0) ? 0 : ((blk % 4 == 1) ? 5 : 40);
            key_pct = $urandom_range(10, 40);
            for (int c = 0; c < 100; c++) begin
                int r;
                key_valid = ($urandom_range(0, 99) < key_pct);
                r = $urandom_range(0, 9);
                key_code = (r < 4) ? 4'd8 : ((r < 6) ? 4'd9 : 4'($urandom_range(0, 15)));
                chk_dataready = ($urandom_range(0, 99) < dr_pct);
                chk_correct = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 499) == 0) begin
                    #3 rst = 1'b1;
                    tick();
                    rst = 1'b0;
                end else begin
                    tick();
                end
            end
            $display("random block %0d done, mode=%0d tries=%0d", blk, m_mode, m_tries);
        end
        key_valid = 1'b0; chk_dataready = 1'b0;
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
